tt_daniele_sum_tx: RTL and testbench
====================================

// Module: tt_daniele_sum_tx
// PURPOSE
// - Transmit-side tile for the bidirectional uio pins: accepts operand pairs, adds them and sends each result out as a 2-beat frame.
// - Beat 0 carries the low sum byte; beat 1 carries the carry bit.
// - Drives tx_oe high only while a frame is on the pins, so uio acts as an output only during transmission.
// - Sits between the ui_in operand source and the uio output path at top level.
// PARAMETERS
// - WIDTH  8  operand / pin-bus width
// - DEPTH  4  result FIFO entries; power of 2, >= 2
// PORTS
// - clk        in   1          clock; all state on rising edge
// - rst        in   1          asynchronous, active-high reset
// - a_in       in   WIDTH      operand A
// - b_in       in   WIDTH      operand B
// - in_valid   in   1          operand pair valid
// - in_ready   out  1          pair accepted when in_valid & in_ready
// - tx_data    out  WIDTH      frame beat data (maps to uio_out)
// - tx_oe      out  WIDTH      output enable (maps to uio_oe); all-ones during a frame, else 0
// - tx_valid   out  1          beat valid
// - tx_ready   in   1          receiver accepts beat when tx_valid & tx_ready
// - tx_last    out  1          high on beat 1 of a frame
// - sent_cnt   out  8          completed-frame counter, wraps 255 -> 0
// BEHAVIOUR
// - Reset (async, immediate):
//   - FIFO empty, FSM in IDLE.
//   - tx_data, tx_oe, tx_valid, tx_last, sent_cnt and in_ready all 0.
//   - in_ready is registered; it rises on the first clk edge after rst deasserts.
//   - Reset mid-frame aborts the frame: no completion, sent_cnt unchanged from its reset value of 0.
// - Accept path:
//   - On handshake, push {carry, sum[WIDTH-1:0]} = a_in + b_in as a WIDTH+1-bit value into the FIFO.
//   - in_ready_q <= (next_count != DEPTH).
//   - No bypass path: an accepted pair always passes through the FIFO.
// - FSM states: IDLE, BEAT0, BEAT1.
//   - IDLE: tx_valid=0, tx_data=0, tx_oe=0.
//     - If FIFO is non-empty: pop into hold reg, go to BEAT0.
//   - BEAT0: tx_valid=1, tx_data=hold.sum, tx_last=0, tx_oe='1.
//     - On tx_ready: go to BEAT1.
//   - BEAT1: tx_valid=1, tx_data={WIDTH-1 zeros, hold.carry}, tx_last=1, tx_oe='1.
//     - On tx_ready: sent_cnt+1.
//     - If FIFO is non-empty: pop and go to BEAT0 (back-to-back frames, no IDLE gap). Otherwise go to IDLE.
// - Latency: pair accepted at edge n, with FSM in IDLE and FIFO empty -> tx_valid=1 after edge n+2.
// - All tx_* outputs are registered.
//   - tx_data, tx_last and tx_oe stay stable while tx_valid & !tx_ready.
//   - tx_valid never drops without a handshake.
// - Simultaneous push and pop in one cycle: FIFO count unchanged. A push is allowed when full only if in_ready_q was already 1, which it never is.
// - Capacity: DEPTH FIFO entries + 1 hold register = DEPTH+1 pairs outstanding before in_ready falls.
// - Frame ordering strictly follows acceptance order.
// - Pointers wrap modulo DEPTH.
// - sent_cnt wraps silently.
// STRUCTURE
// - tt_daniele_pkg:
//   - state enum {IDLE, BEAT0, BEAT1}
//   - FRAME_BEATS = 2
//   - default WIDTH/DEPTH constants
// - Sub-module tt_daniele_sync_fifo:
//   - parameters WIDTH+1 and DEPTH
//   - ports push, pop, full, empty, count; async active-high reset
// - Top-level wrapper mapping (not part of this block):
//   - a_in=ui_in, b_in=uio_in, tx_data=uio_out, tx_oe=uio_oe
// TESTING
// 1. Reset: assert rst during BEAT0 -> all outputs 0 the same cycle; in_ready=1 one edge after release; no beat from the aborted frame.
// 2. Single pair a=0x12, b=0x34, tx_ready=1 -> tx_valid 2 edges after accept with beats 0x46/last=0 then 0x00/last=1; tx_oe=0xFF on both beats then 0x00; sent_cnt=1.
// 3. Carry case: 0xFF + 0x01 -> beats 0x00 then 0x01/last=1; 0x80 + 0x80 -> beats 0x00 then 0x01.
// 4. Backpressure: tx_ready=0, offer 6 pairs -> exactly 5 accepted, then in_ready=0; with tx_ready=1, 10 beats in order, in_ready recovers, 6th pair then sent.
// 5. Stall stability: tx_ready pattern 1,0,0,1,0,1 across 3 frames -> tx_data, tx_last and tx_oe unchanged in stalled cycles; no beat lost or duplicated.
// 6. Counter wrap: 257 frames back-to-back with no IDLE cycles between frames -> sent_cnt reads 0x01 at the end.

Source files
------------

// File: rtl/tt_daniele_pkg.sv
// Shared types and constants for the sum-and-transmit tile.
package tt_daniele_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam int FRAME_BEATS   = 2;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/tt_daniele_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is presented combinationally at the head.
module tt_daniele_sync_fifo
    import tt_daniele_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH + 1,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tt_daniele_sum_tx.sv
// Adds operand pairs, queues the results and sends each as a two-beat frame (sum byte, then carry).
module tt_daniele_sum_tx
    import tt_daniele_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] tx_oe,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic [7:0]       sent_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [WIDTH:0] add_pair(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH:0]   hold_q, hold_d;
    logic [WIDTH:0]   fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    next_count;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] oe_d;
    logic             valid_d;
    logic             last_d;
    logic [7:0]       cnt_d;

    assign accept     = in_valid & in_ready;
    assign next_count = fifo_count + CW'(accept) - CW'(pop);

    tt_daniele_sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (add_pair(a_in, b_in)),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Entry into BEAT0 from IDLE takes one cycle to load the output registers;
    // back-to-back entry from BEAT1 loads them directly from the FIFO head.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        valid_d = tx_valid;
        data_d  = tx_data;
        last_d  = tx_last;
        oe_d    = tx_oe;
        cnt_d   = sent_cnt;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
                oe_d    = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_dout;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (!tx_valid) begin
                    valid_d = 1'b1;
                    data_d  = hold_q[WIDTH-1:0];
                    last_d  = 1'b0;
                    oe_d    = '1;
                end else if (tx_ready) begin
                    state_d = BEAT1;
                    data_d  = {{(WIDTH-1){1'b0}}, hold_q[WIDTH]};
                    last_d  = 1'b1;
                end
            end
            BEAT1: begin
                if (tx_ready) begin
                    cnt_d = sent_cnt + 8'd1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = fifo_dout;
                        state_d = BEAT0;
                        data_d  = fifo_dout[WIDTH-1:0];
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        oe_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            tx_oe    <= '0;
            sent_cnt <= '0;
            in_ready <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            tx_valid <= valid_d;
            tx_data  <= data_d;
            tx_last  <= last_d;
            tx_oe    <= oe_d;
            sent_cnt <= cnt_d;
            in_ready <= (next_count != CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_tt_daniele_sum_tx.sv
// Directed bench for the sum-and-transmit tile: reset abort, latency, carry, backpressure, stalls, counter wrap.
module tb_tt_daniele_sum_tx;
    import tt_daniele_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] tx_data;
    logic [7:0] tx_oe;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic [7:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    tt_daniele_sum_tx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_oe    (tx_oe),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] es, input logic ec, input logic [7:0] ecnt);
        a_in = a; b_in = b; in_valid = 1'b1; tx_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step;
        in_valid = 1'b0;
        chk({tag, "_lat0"}, tx_valid, 0);
        step;
        chk({tag, "_lat1"}, tx_valid, 0);
        step;
        chk({tag, "_b0_valid"}, tx_valid, 1);
        chk({tag, "_b0_data"}, tx_data, es);
        chk({tag, "_b0_last"}, tx_last, 0);
        chk({tag, "_b0_oe"}, tx_oe, 8'hFF);
        step;
        chk({tag, "_b1_valid"}, tx_valid, 1);
        chk({tag, "_b1_data"}, tx_data, {7'b0, ec});
        chk({tag, "_b1_last"}, tx_last, 1);
        chk({tag, "_b1_oe"}, tx_oe, 8'hFF);
        step;
        chk({tag, "_end_valid"}, tx_valid, 0);
        chk({tag, "_end_oe"}, tx_oe, 8'h00);
        chk({tag, "_sent_cnt"}, sent_cnt, ecnt);
    endtask

    logic [7:0] av [6];
    logic [7:0] bv [6];
    logic [8:0] ev [6];
    logic [8:0] sv [3];
    int         pat [6];
    int         idx, got, acc, beats, gaps;
    bit         started;

    initial begin
        // Reset state and in_ready rising one edge after release.
        step;
        step;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_oe", tx_oe, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_cnt", sent_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        chk("rel_in_ready_before_edge", in_ready, 0);
        step;
        chk("rel_in_ready_after_edge", in_ready, 1);

        // Reset asserted mid-BEAT0 aborts the frame.
        a_in = 8'h11; b_in = 8'h22; in_valid = 1'b1; tx_ready = 1'b0;
        step;
        in_valid = 1'b0;
        step;
        step;
        chk("abort_pre_valid", tx_valid, 1);
        chk("abort_pre_data", tx_data, 8'h33);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", tx_valid, 0);
        chk("abort_data", tx_data, 0);
        chk("abort_oe", tx_oe, 0);
        chk("abort_last", tx_last, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_cnt", sent_cnt, 0);
        step;
        rst = 1'b0;
        tx_ready = 1'b1;
        step;
        chk("abort_rel_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort_no_beat%0d", i), tx_valid, 0);
            step;
        end
        chk("abort_cnt_after", sent_cnt, 0);

        // Single pair and carry cases.
        send_check("sum_12_34", 8'h12, 8'h34, 8'h46, 1'b0, 8'd1);
        send_check("sum_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 8'd2);
        send_check("sum_80_80", 8'h80, 8'h80, 8'h00, 1'b1, 8'd3);

        // Backpressure: DEPTH + 1 pairs fit, the sixth waits.
        av = '{8'h01, 8'h22, 8'hF0, 8'h7F, 8'h80, 8'hAA};
        bv = '{8'h02, 8'h33, 8'h20, 8'h01, 8'h80, 8'h56};
        for (int i = 0; i < 6; i++) ev[i] = {1'b0, av[i]} + {1'b0, bv[i]};
        tx_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                a_in = av[idx];
                b_in = bv[idx];
            end
            if (in_valid && in_ready) idx++;
            step;
        end
        chk("bp_accepted", idx, 5);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_stalled_data", tx_data, ev[0][7:0]);
        tx_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 12; c++) begin
            if (in_valid && in_ready) idx++;
            if (tx_valid) begin
                int f;
                f = got / FRAME_BEATS;
                if (got % FRAME_BEATS == 0) begin
                    chk($sformatf("bp_data%0d", got), tx_data, ev[f][7:0]);
                    chk($sformatf("bp_last%0d", got), tx_last, 0);
                end else begin
                    chk($sformatf("bp_data%0d", got), tx_data, {7'b0, ev[f][8]});
                    chk($sformatf("bp_last%0d", got), tx_last, 1);
                end
                chk($sformatf("bp_oe%0d", got), tx_oe, 8'hFF);
                got++;
            end
            step;
            if (idx == 6) in_valid = 1'b0;
        end
        chk("bp_beats", got, 12);
        chk("bp_sixth_accepted", idx, 6);
        chk("bp_sent_cnt", sent_cnt, 9);

        // Stall stability across three queued frames.
        tx_ready = 1'b0;
        sv[0] = 9'h011; sv[1] = 9'h110; sv[2] = 9'h00B;
        a_in = 8'h10; b_in = 8'h01; in_valid = 1'b1;
        chk("st_in_ready0", in_ready, 1);
        step;
        a_in = 8'hC0; b_in = 8'h50;
        chk("st_in_ready1", in_ready, 1);
        step;
        a_in = 8'h05; b_in = 8'h06;
        chk("st_in_ready2", in_ready, 1);
        step;
        in_valid = 1'b0;
        pat = '{1, 0, 0, 1, 0, 1};
        got = 0;
        started = 1'b0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            tx_ready = pat[c % 6][0];
            if (tx_valid) begin
                started = 1'b1;
                if (got % FRAME_BEATS == 0)
                    chk($sformatf("st_data_c%0d", c), tx_data, sv[got / FRAME_BEATS][7:0]);
                else
                    chk($sformatf("st_data_c%0d", c), tx_data, {7'b0, sv[got / FRAME_BEATS][8]});
                chk($sformatf("st_last_c%0d", c), tx_last, (got % FRAME_BEATS) == 1);
                chk($sformatf("st_oe_c%0d", c), tx_oe, 8'hFF);
                if (tx_ready) got++;
            end else if (started) begin
                chk($sformatf("st_valid_drop_c%0d", c), tx_valid, 1);
            end
            step;
        end
        chk("st_beats", got, 6);
        chk("st_sent_cnt", sent_cnt, 12);

        // Counter wrap over 257 back-to-back frames from a fresh reset.
        tx_ready = 1'b1;
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        chk("wrap_cnt_start", sent_cnt, 0);
        a_in = 8'h01; b_in = 8'h02; in_valid = 1'b1;
        acc = 0; beats = 0; gaps = 0; started = 1'b0;
        for (int c = 0; c < 3000 && beats < 514; c++) begin
            if (in_valid && in_ready) acc++;
            if (tx_valid) begin
                started = 1'b1;
                beats++;
            end else if (started) begin
                gaps++;
            end
            step;
            if (acc == 257) in_valid = 1'b0;
        end
        chk("wrap_accepted", acc, 257);
        chk("wrap_beats", beats, 514);
        chk("wrap_gaps", gaps, 0);
        chk("wrap_sent_cnt", sent_cnt, 8'h01);
        chk("wrap_idle_valid", tx_valid, 0);
        chk("wrap_idle_oe", tx_oe, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
